// File: rtl/accum_stream_dbl.sv
// Streaming multi-beat accumulator for the 68-bit register double format.
// Lanes are aligned to a running max exponent, summed wide, then normalised and rounded once per group.
module accum_stream_dbl #(
    parameter int LANES = 4,
    parameter int ACC_W = 128,
    parameter int HEAD  = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic                in_neg,
    input  logic [LANES-1:0]    in_mask,
    input  logic [LANES*68-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [67:0]         out_data,
    output logic                out_nan,
    output logic                out_ovf
);
    localparam int              PW      = $clog2(ACC_W);
    localparam int              SH      = ACC_W - HEAD - 52;
    localparam logic [11:0]     ACCW_E  = 12'(ACC_W);
    localparam logic [PW-1:0]   MSB_IDX = PW'(ACC_W - 1);
    localparam logic [15:0]     TOP_E   = 16'(ACC_W - HEAD - 1);

    typedef enum logic {ST_ACCEPT, ST_DRAIN} state_t;

    state_t state_q, state_d;
    logic   beatFire;

    assign beatFire = in_valid && in_ready;
    assign in_ready = (state_q == ST_ACCEPT) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_ACCEPT;
        else     state_q <= state_d;
    end

    // Closed once the last beat is taken; reopened only when the result is consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: if (beatFire && in_last)      state_d = ST_DRAIN;
            ST_DRAIN:  if (out_valid && out_ready)   state_d = ST_ACCEPT;
            default:                                 state_d = ST_ACCEPT;
        endcase
    end

    logic [LANES-1:0][11:0] inExp;
    logic [LANES-1:0][50:0] inFrac;
    logic [LANES-1:0]       inSign, inLive;
    logic [LANES*4-1:0]     unused_in;
    logic [11:0]            bmax;
    logic                   beatNan;

    always_comb begin
        bmax    = '0;
        beatNan = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            inExp[k]            = {in_data[68*k+64], in_data[68*k+52 +: 11]};
            inFrac[k]           = {in_data[68*k+33 +: 19], in_data[68*k +: 32]};
            inSign[k]           = in_data[68*k+63];
            unused_in[4*k +: 4] = {in_data[68*k+65 +: 3], in_data[68*k+32]};
            inLive[k]           = in_mask[k] && (inExp[k] != 12'h000) && (inExp[k] != 12'hfff);
            if (in_mask[k] && inExp[k] == 12'hfff) beatNan = 1'b1;
            if (inLive[k] && inExp[k] > bmax)      bmax = inExp[k];
        end
    end

    logic                   s1Valid_q, s1Last_q, s1Neg_q, s1Nan_q;
    logic [11:0]            s1Bmax_q;
    logic [LANES-1:0][11:0] s1Exp_q;
    logic [LANES-1:0][50:0] s1Frac_q;
    logic [LANES-1:0]       s1Sign_q, s1Live_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Neg_q   <= 1'b0;
            s1Nan_q   <= 1'b0;
            s1Bmax_q  <= '0;
            s1Exp_q   <= '0;
            s1Frac_q  <= '0;
            s1Sign_q  <= '0;
            s1Live_q  <= '0;
        end else begin
            s1Valid_q <= beatFire;
            if (beatFire) begin
                s1Last_q <= in_last;
                s1Neg_q  <= in_neg;
                s1Nan_q  <= beatNan;
                s1Bmax_q <= bmax;
                s1Exp_q  <= inExp;
                s1Frac_q <= inFrac;
                s1Sign_q <= inSign;
                s1Live_q <= inLive;
            end
        end
    end

    logic [11:0]      accExp_q, refExp, dshD, shAmt;
    logic [ACC_W-1:0] sumD, term;

    always_comb begin
        refExp = (s1Bmax_q > accExp_q) ? s1Bmax_q : accExp_q;
        dshD   = refExp - accExp_q;
        sumD   = '0;
        shAmt  = '0;
        term   = '0;
        for (int k = 0; k < LANES; k++) begin
            shAmt = refExp - s1Exp_q[k];
            term  = ACC_W'({1'b1, s1Frac_q[k]}) << SH;
            if (!s1Live_q[k] || shAmt >= ACCW_E) term = '0;
            else                                 term = term >> shAmt;
            if (s1Sign_q[k] ^ s1Neg_q) term = -term;
            sumD = sumD + term;
        end
    end

    logic             s2Valid_q, s2Last_q, s2Nan_q;
    logic [11:0]      s2Dsh_q;
    logic [ACC_W-1:0] s2Sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2Nan_q   <= 1'b0;
            s2Dsh_q   <= '0;
            s2Sum_q   <= '0;
            accExp_q  <= '0;
        end else begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Last_q <= s1Last_q;
                s2Nan_q  <= s1Nan_q;
                s2Dsh_q  <= dshD;
                s2Sum_q  <= sumD;
            end
            if (s2Valid_q && s2Last_q) accExp_q <= '0;
            else if (s1Valid_q)        accExp_q <= refExp;
        end
    end

    logic [ACC_W-1:0] acc_q, accShift, accD;

    always_comb begin
        if (s2Dsh_q >= ACCW_E) accShift = {ACC_W{acc_q[ACC_W-1]}};
        else                   accShift = ACC_W'($signed(acc_q) >>> s2Dsh_q);
        accD = accShift + s2Sum_q;
    end

    logic             nanSticky_q, s3Valid_q, finNan_q;
    logic [11:0]      finExp_q;
    logic [ACC_W-1:0] finAcc_q;

    // The last beat hands the total to the normaliser and leaves a clean accumulator behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            nanSticky_q <= 1'b0;
            s3Valid_q   <= 1'b0;
            finNan_q    <= 1'b0;
            finExp_q    <= '0;
            finAcc_q    <= '0;
        end else begin
            s3Valid_q <= s2Valid_q && s2Last_q;
            if (s2Valid_q) begin
                if (s2Last_q) begin
                    acc_q       <= '0;
                    nanSticky_q <= 1'b0;
                    finAcc_q    <= accD;
                    finNan_q    <= nanSticky_q || s2Nan_q;
                    finExp_q    <= accExp_q;
                end else begin
                    acc_q       <= accD;
                    nanSticky_q <= nanSticky_q || s2Nan_q;
                end
            end
        end
    end

    logic             finSgn;
    logic [ACC_W-1:0] finMag;
    logic [PW-1:0]    leadD;

    always_comb begin
        finSgn = finAcc_q[ACC_W-1];
        finMag = finSgn ? -finAcc_q : finAcc_q;
        leadD  = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (finMag[i]) leadD = PW'(i);
        end
    end

    logic             s4Valid_q, s4Sgn_q, s4Nan_q;
    logic [PW-1:0]    s4Lead_q;
    logic [11:0]      s4Exp_q;
    logic [ACC_W-1:0] s4Mag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s4Valid_q <= 1'b0;
            s4Sgn_q   <= 1'b0;
            s4Nan_q   <= 1'b0;
            s4Lead_q  <= '0;
            s4Exp_q   <= '0;
            s4Mag_q   <= '0;
        end else begin
            s4Valid_q <= s3Valid_q;
            if (s3Valid_q) begin
                s4Sgn_q  <= finSgn;
                s4Nan_q  <= finNan_q;
                s4Lead_q <= leadD;
                s4Exp_q  <= finExp_q;
                s4Mag_q  <= finMag;
            end
        end
    end

    logic [PW-1:0]    normSh;
    logic [ACC_W-1:0] norm;
    logic             unused_norm;
    logic [51:0]      fracR;
    logic [15:0]      expW;
    logic [67:0]      outData_d;
    logic             outNan_d, outOvf_d;

    // Leading one moves to the MSB; a rounding carry leaves fracR[50:0] zero and bumps the exponent.
    always_comb begin
        normSh      = MSB_IDX - s4Lead_q;
        norm        = s4Mag_q << normSh;
        unused_norm = ^{norm[ACC_W-1], norm[ACC_W-54:0]};
        fracR       = {1'b0, norm[ACC_W-2 -: 51]} + 52'(norm[ACC_W-53]);
        expW        = 16'(s4Exp_q) + 16'(s4Lead_q) + 16'(fracR[51]) - TOP_E;
        outData_d   = '0;
        outNan_d    = 1'b0;
        outOvf_d    = 1'b0;
        if (s4Nan_q) begin
            outData_d = {3'b000, 1'b1, 1'b0, 11'h7ff, 19'h40000, 33'h0};
            outNan_d  = 1'b1;
        end else if (s4Mag_q == '0 || expW[15] || expW == 16'h0000) begin
            outData_d = '0;
        end else if (expW >= 16'h0fff) begin
            outData_d = {3'b000, 1'b1, s4Sgn_q, 11'h7ff, 52'h0};
            outOvf_d  = 1'b1;
        end else begin
            outData_d = {3'b000, expW[11], s4Sgn_q, expW[10:0], fracR[50:32], 1'b0, fracR[31:0]};
        end
    end

    logic        outValid_q, outNan_q, outOvf_q;
    logic [67:0] outData_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outNan_q   <= 1'b0;
            outOvf_q   <= 1'b0;
            outData_q  <= '0;
        end else if (s4Valid_q) begin
            outValid_q <= 1'b1;
            outNan_q   <= outNan_d;
            outOvf_q   <= outOvf_d;
            outData_q  <= outData_d;
        end else if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_nan   = outNan_q;
    assign out_ovf   = outOvf_q;

endmodule

// File: doc/accum_stream_dbl.md
# accum_stream_dbl

Streaming multi-beat accumulator for the 68-bit register double format. Accepts LANES operands per beat over any number of beats. Aligns each operand to a running maximum exponent and sums into a wide two's-complement accumulator. Normalises and rounds once, when the group's last beat has been summed. It is the parametrised successor of the fixed 109-input accumulate-buffer unit and sits behind the explicit accumulate instruction in the FP math cluster.

## Interface
- LANES, 4, operands per beat (1..16)
- ACC_W, 128, accumulator width in bits (≥ 80)
- HEAD, 12, headroom bits above the aligned significand MSB
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  beat closes the group
- in_neg  in  1  negate every lane of this beat (accumulate-subtract)
- in_mask  in  LANES  lane enable; a masked lane contributes zero
- in_data  in  LANES*68  lane k at [68k+67:68k]
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  result accepted when out_valid && out_ready
- out_data  out  68  result
- out_nan  out  1  group contained an operand with exponent 12'hfff
- out_ovf  out  1  result saturated to infinity

## Operation
- Operand format:
  - sign d[63]
  - exponent e = {d[64],d[62:52]}, 12 bits, bias 2047
  - fraction f[50:0] = {d[51:33],d[31:0]}; d[32] is ignored on input and is always 0 on output
  - significand S = {1,f}, 52 bits
  - e==0 is treated as zero (denormals flushed)
- Stage 1: register the beat and compute bmax, the maximum e over unmasked lanes with e≠12'hfff.
- Stage 2: ref = max(acc_exp, bmax). Update acc_exp to ref in this stage. Record dsh = ref − old acc_exp.
  - term = (S << (ACC_W−HEAD−52)) >> (ref − e), logical shift; a shift ≥ ACC_W gives 0.
  - Negate term if sign XOR in_neg.
- Stage 3: acc <= (acc >>> min(dsh, ACC_W)) + Σ terms, two's complement, wrap on overflow.
  - Back-to-back beats are legal: acc_exp belongs to stage 2 and acc to stage 3.
- Stage 4, on the last beat only: mag = |acc|, sgn = acc MSB. Find p, the leading-one index of mag.
- Stage 5: result exponent E = acc_exp + p − (ACC_W−HEAD−1). Fraction = 51 bits below the leading one.
  - Rounding: round half away from zero using the next bit. A carry out of the fraction increments E.
- Output rules, first match wins:
  - nan sticky set → sign 0, exp 12'hfff, f = 51'h4_0000_0000_0000, out_nan=1
  - mag==0 or E≤0 → all-zero +0
  - E≥12'hfff → sign=sgn, exp 12'hfff, f=0, out_ovf=1
  - otherwise normal
- Group end: after the last beat passes stage 3, clear acc, acc_exp and nan sticky for the next group.
- Flow control:
  - in_ready deasserts the cycle after the last beat is accepted.
  - in_ready reasserts the cycle after out_valid && out_ready.
  - Only one group is in normalisation at a time.
- A group whose lanes are all masked gives +0.

## Timing
- Last beat accepted in cycle T → out_valid asserted in cycle T+5.
- Non-last beats: one per cycle, no bubbles.
- out_data, out_nan and out_ovf are stable while out_valid && !out_ready.
- out_valid drops the cycle after acceptance.
- Reset values: in_ready=0 during rst and 1 from the first cycle after. out_valid=0, out_data=0, out_nan=0, out_ovf=0. acc=0, acc_exp=0, all stage valids 0.
- Reset in mid-group or mid-normalise discards all in-flight state; no output is produced.
- in_valid while in_ready=0 is ignored; no beat is accepted.

## Test plan
- LANES=4, one beat: lanes 0,1 = 1.0 (e=12'h7ff, f=0), mask 4'b0011, last → at T+5, out_data e=12'h800, f=0, sign 0.
- One beat: 1.0 and −1.0 (d[63]=1), last → out_data = 68'h0, out_ovf=0.
- Beat 1: 1.0. Beat 2: 2^10 (e=12'h809). last on beat 2 → result 1025.0: e=12'h809, only d[42] set in the fraction. Checks the acc right-shift path.
- 3.0 (e=12'h800, d[51]=1) with in_neg=1 → sign 1, e=12'h800, d[51]=1.
- NaN: one lane with e=12'hfff among normal lanes → out_nan=1, out_data e=12'hfff, d[51]=1, other fraction bits 0.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles → out_data stable, in_ready=0; in_ready returns 1 the cycle after acceptance.
  - Separately, assert rst two beats into a group → no out_valid; a following group of 1.0+1.0 gives 2.0.
